scan_sequencer: RTL and testbench

SCAN_SEQUENCER -- requirements
Module: scan_sequencer

---
 rtl/comptest_pkg.sv | 28 ++
 rtl/scan_settle_timer.sv | 31 +++
 rtl/scan_sequencer.sv | 230 +++++++++++++++++++++++
 tb/tb_scan_sequencer.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/comptest_pkg.sv
// comptest_pkg -- definitions shared by the comparator-test scan logic.
//   SCAN_TIMEOUT_DEFAULT : cycles allowed for the injector to drop its ready flag
//   ST_*                 : scan sequencer state encoding (3-bit, legacy-compatible)
//   scan_cfg_t           : configuration fields held for the duration of a scan
//   strip_onehot()       : half-strip number -> one-hot 32-bit pattern
package comptest_pkg;

  localparam int SCAN_TIMEOUT_DEFAULT = 16;

  localparam logic [2:0] ST_IDLE       = 3'd0;
  localparam logic [2:0] ST_SETTLE     = 3'd1;
  localparam logic [2:0] ST_FIRE       = 3'd2;
  localparam logic [2:0] ST_WAIT_BUSY  = 3'd3;
  localparam logic [2:0] ST_WAIT_READY = 3'd4;
  localparam logic [2:0] ST_CHECK      = 3'd5;
  localparam logic [2:0] ST_NEXT       = 3'd6;
  localparam logic [2:0] ST_DONE       = 3'd7;

  typedef struct packed {
    logic [4:0] last_strip;
    logic [7:0] settle;
  } scan_cfg_t;

  function automatic logic [31:0] strip_onehot(input logic [4:0] strip);
    strip_onehot = 32'h1 << strip;
  endfunction

endpackage

// File: rtl/scan_settle_timer.sv
// scan_settle_timer -- loadable down-counter with a zero flag.
//   clock, reset_n : clock, synchronous active-low reset
//   load, load_val : load the counter (load has priority over dec)
//   dec            : decrement by one, stopping at zero
//   zero           : counter currently reads zero
module scan_settle_timer #(
  parameter int W = 8
) (
  input  logic         clock,
  input  logic         reset_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic         zero
);

  logic [W-1:0] count_reg;

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      count_reg <= '0;
    end else if (load) begin
      count_reg <= load_val;
    end else if (dec && (count_reg != '0)) begin
      count_reg <= count_reg - W'(1);
    end
  end

  assign zero = (count_reg == '0);

endmodule

// File: rtl/scan_sequencer.sv
// scan_sequencer -- steps the comparator injector across a half-strip range,
// firing num_pulses pulses per half-strip and comparing each latched result
// with the one-hot expected pattern.
//   Inputs : clock, reset_n (sync, active low), start, abort, first_strip,
//            last_strip, num_pulses, settle_cycles, pulser_ready, halfstrips_last
//   Outputs: fire_pulse, halfstrips_expect, active_strip_mask, scan_strip,
//            busy, done, cfg_err, timeout_err, err_cnt, strip_err_flags
// All outputs come straight from registers.
module scan_sequencer
  import comptest_pkg::*;
#(
  parameter int NPULSE_W = 16,
  parameter int TIMEOUT  = SCAN_TIMEOUT_DEFAULT
) (
  input  logic                clock,
  input  logic                reset_n,
  input  logic                start,
  input  logic                abort,
  input  logic [4:0]          first_strip,
  input  logic [4:0]          last_strip,
  input  logic [NPULSE_W-1:0] num_pulses,
  input  logic [7:0]          settle_cycles,
  input  logic                pulser_ready,
  input  logic [31:0]         halfstrips_last,
  output logic                fire_pulse,
  output logic [31:0]         halfstrips_expect,
  output logic [31:0]         active_strip_mask,
  output logic [4:0]          scan_strip,
  output logic                busy,
  output logic                done,
  output logic                cfg_err,
  output logic                timeout_err,
  output logic [NPULSE_W-1:0] err_cnt,
  output logic [31:0]         strip_err_flags
);

  // The timer serves both the 8-bit settle count and the TIMEOUT window.
  localparam int TMR_W = ($clog2(TIMEOUT) > 8) ? $clog2(TIMEOUT) : 8;
  localparam logic [TMR_W-1:0] TIMEOUT_LOAD = TMR_W'(TIMEOUT - 1);

  logic [2:0]          state_reg, state_next;
  logic                fire_reg, fire_next;
  logic [4:0]          strip_reg, strip_next;
  logic [31:0]         expect_reg, expect_next;
  logic                busy_reg, busy_next;
  logic                done_reg, done_next;
  logic                cfg_err_reg, cfg_err_next;
  logic                tmo_reg, tmo_next;
  logic [NPULSE_W-1:0] err_cnt_reg, err_cnt_next;
  logic [31:0]         flags_reg, flags_next;
  logic [NPULSE_W-1:0] pulse_cnt_reg, pulse_cnt_next;
  logic [NPULSE_W-1:0] num_pulses_reg, num_pulses_next;
  scan_cfg_t           cfg_reg, cfg_next;
  logic                skip_cmp_reg, skip_cmp_next;  // pulse already scored by a timeout

  logic                tmr_load, tmr_dec, tmr_zero;
  logic [TMR_W-1:0]    tmr_val;

  scan_settle_timer #(.W(TMR_W)) u_timer (
    .clock    (clock),
    .reset_n  (reset_n),
    .load     (tmr_load),
    .load_val (tmr_val),
    .dec      (tmr_dec),
    .zero     (tmr_zero)
  );

  always_comb begin
    state_next      = state_reg;
    fire_next       = 1'b0;
    strip_next      = strip_reg;
    busy_next       = busy_reg;
    done_next       = done_reg;
    cfg_err_next    = cfg_err_reg;
    tmo_next        = tmo_reg;
    err_cnt_next    = err_cnt_reg;
    flags_next      = flags_reg;
    pulse_cnt_next  = pulse_cnt_reg;
    num_pulses_next = num_pulses_reg;
    cfg_next        = cfg_reg;
    skip_cmp_next   = skip_cmp_reg;
    tmr_load        = 1'b0;
    tmr_dec         = 1'b0;
    tmr_val         = '0;

    if (abort && (state_reg != ST_IDLE) && (state_reg != ST_DONE)) begin
      state_next = ST_IDLE;
      busy_next  = 1'b0;
      done_next  = 1'b0;
    end else if (!abort) begin
      // An idle-state abort still suppresses a coincident start.
      case (state_reg)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            if ((first_strip <= last_strip) && (num_pulses != '0)) begin
              busy_next             = 1'b1;
              done_next             = 1'b0;
              cfg_err_next          = 1'b0;
              tmo_next              = 1'b0;
              err_cnt_next          = '0;
              flags_next            = '0;
              pulse_cnt_next        = '0;
              skip_cmp_next         = 1'b0;
              strip_next            = first_strip;
              num_pulses_next       = num_pulses;
              cfg_next.last_strip   = last_strip;
              cfg_next.settle       = settle_cycles;
              if (settle_cycles == 8'd0) begin
                state_next = ST_FIRE;
              end else begin
                state_next = ST_SETTLE;
                tmr_load   = 1'b1;
                tmr_val    = TMR_W'(settle_cycles) - TMR_W'(1);
              end
            end else begin
              cfg_err_next = 1'b1;
              done_next    = 1'b1;
              busy_next    = 1'b0;
              state_next   = ST_DONE;
            end
          end
        end
        ST_SETTLE: begin
          // Timer was loaded with settle-1, so SETTLE spans exactly settle cycles.
          if (tmr_zero) state_next = ST_FIRE;
          else          tmr_dec    = 1'b1;
        end
        ST_FIRE: begin
          if (pulser_ready) begin
            fire_next  = 1'b1;
            state_next = ST_WAIT_BUSY;
            tmr_load   = 1'b1;
            tmr_val    = TIMEOUT_LOAD;
          end
        end
        ST_WAIT_BUSY: begin
          if (!pulser_ready) begin
            state_next = ST_WAIT_READY;
          end else if (tmr_zero) begin
            tmo_next              = 1'b1;
            skip_cmp_next         = 1'b1;
            flags_next[strip_reg] = 1'b1;
            if (err_cnt_reg != '1) err_cnt_next = err_cnt_reg + NPULSE_W'(1);
            state_next = ST_CHECK;
          end else begin
            tmr_dec = 1'b1;
          end
        end
        ST_WAIT_READY: begin
          if (pulser_ready) state_next = ST_CHECK;
        end
        ST_CHECK: begin
          skip_cmp_next = 1'b0;
          if (!skip_cmp_reg && (halfstrips_last != expect_reg)) begin
            flags_next[strip_reg] = 1'b1;
            if (err_cnt_reg != '1) err_cnt_next = err_cnt_reg + NPULSE_W'(1);
          end
          pulse_cnt_next = pulse_cnt_reg + NPULSE_W'(1);
          state_next     = (pulse_cnt_next == num_pulses_reg) ? ST_NEXT : ST_FIRE;
        end
        ST_NEXT: begin
          pulse_cnt_next = '0;
          if (strip_reg == cfg_reg.last_strip) begin
            state_next = ST_DONE;
            busy_next  = 1'b0;
            done_next  = 1'b1;
          end else begin
            strip_next = strip_reg + 5'd1;
            if (cfg_reg.settle == 8'd0) begin
              state_next = ST_FIRE;
            end else begin
              state_next = ST_SETTLE;
              tmr_load   = 1'b1;
              tmr_val    = TMR_W'(cfg_reg.settle) - TMR_W'(1);
            end
          end
        end
        default: state_next = ST_IDLE;
      endcase
    end

    expect_next = strip_onehot(strip_next);
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_reg      <= ST_IDLE;
      fire_reg       <= 1'b0;
      strip_reg      <= '0;
      expect_reg     <= 32'h1;
      busy_reg       <= 1'b0;
      done_reg       <= 1'b0;
      cfg_err_reg    <= 1'b0;
      tmo_reg        <= 1'b0;
      err_cnt_reg    <= '0;
      flags_reg      <= '0;
      pulse_cnt_reg  <= '0;
      num_pulses_reg <= '0;
      cfg_reg        <= '0;
      skip_cmp_reg   <= 1'b0;
    end else begin
      state_reg      <= state_next;
      fire_reg       <= fire_next;
      strip_reg      <= strip_next;
      expect_reg     <= expect_next;
      busy_reg       <= busy_next;
      done_reg       <= done_next;
      cfg_err_reg    <= cfg_err_next;
      tmo_reg        <= tmo_next;
      err_cnt_reg    <= err_cnt_next;
      flags_reg      <= flags_next;
      pulse_cnt_reg  <= pulse_cnt_next;
      num_pulses_reg <= num_pulses_next;
      cfg_reg        <= cfg_next;
      skip_cmp_reg   <= skip_cmp_next;
    end
  end

  assign fire_pulse        = fire_reg;
  assign halfstrips_expect = expect_reg;
  assign active_strip_mask = expect_reg;
  assign scan_strip        = strip_reg;
  assign busy              = busy_reg;
  assign done              = done_reg;
  assign cfg_err           = cfg_err_reg;
  assign timeout_err       = tmo_reg;
  assign err_cnt           = err_cnt_reg;
  assign strip_err_flags   = flags_reg;

endmodule

// File: tb/tb_scan_sequencer.sv
// tb_scan_sequencer -- directed self-checking bench for scan_sequencer with a
// behavioural comparator-injector model (echo / zero-on-strip-4 / stuck-ready).
module tb_scan_sequencer;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic [4:0]  first_strip = '0;
  logic [4:0]  last_strip = '0;
  logic [15:0] num_pulses = '0;
  logic [7:0]  settle_cycles = '0;
  logic        pulser_ready = 1'b1;
  logic [31:0] halfstrips_last = '0;
  logic        fire_pulse;
  logic [31:0] halfstrips_expect;
  logic [31:0] active_strip_mask;
  logic [4:0]  scan_strip;
  logic        busy, done, cfg_err, timeout_err;
  logic [15:0] err_cnt;
  logic [31:0] strip_err_flags;

  int n_cmp = 0;
  int n_fail = 0;

  // Injector model: 0 = echo expected pattern, 1 = return 0 on strip 4, 2 = ready stuck high
  int inj_mode = 0;
  int fire_count = 0;
  int dbl_fire = 0;
  int busy_cnt = 0;
  logic prev_fire = 1'b0;
  logic [4:0] inj_strip = '0;

  scan_sequencer #(.NPULSE_W(16), .TIMEOUT(16)) dut (
    .clock             (clock),
    .reset_n           (reset_n),
    .start             (start),
    .abort             (abort),
    .first_strip       (first_strip),
    .last_strip        (last_strip),
    .num_pulses        (num_pulses),
    .settle_cycles     (settle_cycles),
    .pulser_ready      (pulser_ready),
    .halfstrips_last   (halfstrips_last),
    .fire_pulse        (fire_pulse),
    .halfstrips_expect (halfstrips_expect),
    .active_strip_mask (active_strip_mask),
    .scan_strip        (scan_strip),
    .busy              (busy),
    .done              (done),
    .cfg_err           (cfg_err),
    .timeout_err       (timeout_err),
    .err_cnt           (err_cnt),
    .strip_err_flags   (strip_err_flags)
  );

  always #5 clock = ~clock;

  always @(posedge clock) begin
    prev_fire <= fire_pulse;
    if (fire_pulse) fire_count <= fire_count + 1;
    if (fire_pulse && prev_fire) dbl_fire <= dbl_fire + 1;
    if (!reset_n) begin
      pulser_ready    <= 1'b1;
      busy_cnt        <= 0;
      halfstrips_last <= '0;
    end else if (inj_mode == 2) begin
      pulser_ready <= 1'b1;
    end else if (fire_pulse) begin
      pulser_ready <= 1'b0;
      busy_cnt     <= 3;
      inj_strip    <= scan_strip;
    end else if (busy_cnt != 0) begin
      busy_cnt <= busy_cnt - 1;
      if (busy_cnt == 1) begin
        pulser_ready    <= 1'b1;
        halfstrips_last <= (inj_mode == 1 && inj_strip == 5'd4) ? 32'h0 : (32'h1 << inj_strip);
      end
    end
  end

  task automatic start_scan(input logic [4:0] f, input logic [4:0] l, input logic [15:0] n, input logic [7:0] s);
    @(negedge clock);
    first_strip = f; last_strip = l; num_pulses = n; settle_cycles = s; start = 1'b1;
    @(negedge clock);
    start = 1'b0;
  endtask

  task automatic wait_done(input int max_cycles, output bit ok);
    int n = 0;
    ok = 1'b0;
    while (n < max_cycles && !ok) begin
      if (done) ok = 1'b1;
      else begin @(negedge clock); n++; end
    end
  endtask

  task automatic test_reset;
    reset_n = 1'b0;
    repeat (2) @(negedge clock);
    n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %0b want 0", busy); end
    n_cmp++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %0b want 0", done); end
    n_cmp++; if (fire_pulse !== 1'b0) begin n_fail++; $display("FAIL reset_fire: got %0b want 0", fire_pulse); end
    n_cmp++; if (halfstrips_expect !== 32'h1) begin n_fail++; $display("FAIL reset_expect: got %08h want 00000001", halfstrips_expect); end
    n_cmp++; if (scan_strip !== 5'd0) begin n_fail++; $display("FAIL reset_strip: got %0d want 0", scan_strip); end
    reset_n = 1'b1;
    @(negedge clock);
    $display("reset released at %0t", $time);
  endtask

  task automatic test_cfg_error;
    int base;
    inj_mode = 0;
    base = fire_count;
    start_scan(5'd7, 5'd2, 16'd2, 8'd1);
    n_cmp++; if (cfg_err !== 1'b1) begin n_fail++; $display("FAIL cfg_err_range: got %0b want 1", cfg_err); end
    n_cmp++; if (done !== 1'b1) begin n_fail++; $display("FAIL cfg_done_range: got %0b want 1", done); end
    n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL cfg_busy_range: got %0b want 0", busy); end
    repeat (10) @(negedge clock);
    n_cmp++; if (fire_count !== base) begin n_fail++; $display("FAIL cfg_no_fire: got %0d want %0d", fire_count, base); end
    start_scan(5'd1, 5'd1, 16'd0, 8'd0);
    n_cmp++; if (cfg_err !== 1'b1 || busy !== 1'b0) begin n_fail++; $display("FAIL cfg_zero_pulses: got cfg_err=%0b busy=%0b want 1/0", cfg_err, busy); end
    $display("cfg error scans: fires=%0d", fire_count - base);
  endtask

  task automatic test_full_scan;
    int base, n;
    bit ok;
    inj_mode = 0;
    base = fire_count;
    start_scan(5'd3, 5'd5, 16'd2, 8'd4);
    n_cmp++; if (busy !== 1'b1 || done !== 1'b0 || cfg_err !== 1'b0) begin n_fail++; $display("FAIL full_start_flags: got busy=%0b done=%0b cfg_err=%0b want 1/0/0", busy, done, cfg_err); end
    n = 1;
    while (!fire_pulse && n < 50) begin @(negedge clock); n++; end
    n_cmp++; if (n !== 6) begin n_fail++; $display("FAIL full_settle_latency: got %0d want 6", n); end
    n_cmp++; if (halfstrips_expect !== 32'h8 || active_strip_mask !== 32'h8 || scan_strip !== 5'd3) begin n_fail++; $display("FAIL full_first_expect: got %08h/%08h/%0d want 00000008/00000008/3", halfstrips_expect, active_strip_mask, scan_strip); end
    // Config changes and a start while busy must not disturb the scan.
    first_strip = 5'd0; last_strip = 5'd31; num_pulses = 16'd7; settle_cycles = 8'd0;
    start = 1'b1; @(negedge clock); start = 1'b0;
    wait_done(2000, ok);
    n_cmp++; if (!ok) begin n_fail++; $display("FAIL full_wait_done: got no done want done within 2000 cycles"); end
    n_cmp++; if (fire_count - base !== 6) begin n_fail++; $display("FAIL full_fire_count: got %0d want 6", fire_count - base); end
    n_cmp++; if (err_cnt !== 16'd0 || strip_err_flags !== 32'h0) begin n_fail++; $display("FAIL full_errors: got err_cnt=%0d flags=%08h want 0/00000000", err_cnt, strip_err_flags); end
    n_cmp++; if (busy !== 1'b0 || scan_strip !== 5'd5 || timeout_err !== 1'b0) begin n_fail++; $display("FAIL full_end_state: got busy=%0b strip=%0d tmo=%0b want 0/5/0", busy, scan_strip, timeout_err); end
    $display("full scan 3..5 x2: fires=%0d err_cnt=%0d", fire_count - base, err_cnt);
  endtask

  task automatic test_mismatch;
    int base;
    bit ok;
    inj_mode = 1;
    base = fire_count;
    start_scan(5'd3, 5'd5, 16'd2, 8'd4);
    wait_done(2000, ok);
    n_cmp++; if (!ok) begin n_fail++; $display("FAIL mis_wait_done: got no done want done within 2000 cycles"); end
    n_cmp++; if (err_cnt !== 16'd2) begin n_fail++; $display("FAIL mis_err_cnt: got %0d want 2", err_cnt); end
    n_cmp++; if (strip_err_flags !== 32'h10) begin n_fail++; $display("FAIL mis_flags: got %08h want 00000010", strip_err_flags); end
    n_cmp++; if (fire_count - base !== 6) begin n_fail++; $display("FAIL mis_fire_count: got %0d want 6", fire_count - base); end
    $display("mismatch scan 3..5 x2: err_cnt=%0d flags=%08h", err_cnt, strip_err_flags);
  endtask

  task automatic test_timeout;
    int base, n;
    bit ok;
    inj_mode = 2;
    base = fire_count;
    start_scan(5'd1, 5'd2, 16'd1, 8'd0);
    n = 0;
    while (!fire_pulse && n < 50) begin @(negedge clock); n++; end
    n_cmp++; if (fire_pulse !== 1'b1) begin n_fail++; $display("FAIL tmo_first_fire: got %0b want 1", fire_pulse); end
    n = 0;
    while (!timeout_err && n < 100) begin @(negedge clock); n++; end
    n_cmp++; if (n !== 16) begin n_fail++; $display("FAIL tmo_latency: got %0d want 16", n); end
    wait_done(2000, ok);
    n_cmp++; if (!ok) begin n_fail++; $display("FAIL tmo_wait_done: got no done want done within 2000 cycles"); end
    n_cmp++; if (err_cnt !== 16'd2 || timeout_err !== 1'b1) begin n_fail++; $display("FAIL tmo_errors: got err_cnt=%0d tmo=%0b want 2/1", err_cnt, timeout_err); end
    n_cmp++; if (fire_count - base !== 2) begin n_fail++; $display("FAIL tmo_fire_count: got %0d want 2", fire_count - base); end
    inj_mode = 0;
    $display("timeout scan 1..2 x1: err_cnt=%0d timeout_err=%0b", err_cnt, timeout_err);
  endtask

  task automatic test_abort;
    int base, n;
    inj_mode = 1;
    base = fire_count;
    start_scan(5'd3, 5'd5, 16'd2, 8'd4);
    n = 0;
    while (!(fire_count == base + 4 && !pulser_ready && scan_strip == 5'd4) && n < 2000) begin @(negedge clock); n++; end
    n_cmp++; if (n >= 2000) begin n_fail++; $display("FAIL abort_reach_wait: got timeout want strip 4 second pulse"); end
    @(negedge clock);
    abort = 1'b1; start = 1'b1;
    @(negedge clock);
    abort = 1'b0; start = 1'b0;
    n_cmp++; if (busy !== 1'b0 || done !== 1'b0 || fire_pulse !== 1'b0) begin n_fail++; $display("FAIL abort_flags: got busy=%0b done=%0b fire=%0b want 0/0/0", busy, done, fire_pulse); end
    n_cmp++; if (err_cnt !== 16'd1 || strip_err_flags !== 32'h10) begin n_fail++; $display("FAIL abort_hold: got err_cnt=%0d flags=%08h want 1/00000010", err_cnt, strip_err_flags); end
    repeat (20) @(negedge clock);
    n_cmp++; if (busy !== 1'b0 || fire_count !== base + 4) begin n_fail++; $display("FAIL abort_stays_idle: got busy=%0b fires=%0d want 0/%0d", busy, fire_count - base, 4); end
    $display("abort on strip 4: err_cnt=%0d fires=%0d", err_cnt, fire_count - base);
  endtask

  task automatic test_reset_mid_settle;
    int base, n;
    inj_mode = 1;
    start_scan(5'd3, 5'd5, 16'd2, 8'd4);
    n = 0;
    while (scan_strip != 5'd5 && n < 2000) begin @(negedge clock); n++; end
    n_cmp++; if (err_cnt !== 16'd2) begin n_fail++; $display("FAIL rst_pre_err: got %0d want 2", err_cnt); end
    reset_n = 1'b0;
    @(negedge clock);
    base = fire_count;
    n_cmp++; if (busy !== 1'b0 || done !== 1'b0 || cfg_err !== 1'b0 || timeout_err !== 1'b0) begin n_fail++; $display("FAIL rst_flags: got busy=%0b done=%0b cfg=%0b tmo=%0b want 0/0/0/0", busy, done, cfg_err, timeout_err); end
    n_cmp++; if (err_cnt !== 16'd0 || strip_err_flags !== 32'h0) begin n_fail++; $display("FAIL rst_errors: got err_cnt=%0d flags=%08h want 0/00000000", err_cnt, strip_err_flags); end
    n_cmp++; if (scan_strip !== 5'd0 || halfstrips_expect !== 32'h1 || active_strip_mask !== 32'h1 || fire_pulse !== 1'b0) begin n_fail++; $display("FAIL rst_outputs: got strip=%0d exp=%08h mask=%08h fire=%0b want 0/00000001/00000001/0", scan_strip, halfstrips_expect, active_strip_mask, fire_pulse); end
    reset_n = 1'b1;
    repeat (30) @(negedge clock);
    n_cmp++; if (fire_count !== base || busy !== 1'b0) begin n_fail++; $display("FAIL rst_no_fire: got fires=%0d busy=%0b want 0/0", fire_count - base, busy); end
    inj_mode = 0;
    $display("reset mid-settle: fires after reset=%0d", fire_count - base);
  endtask

  task automatic test_back_to_back;
    int base;
    bit ok;
    inj_mode = 0;
    base = fire_count;
    start_scan(5'd0, 5'd0, 16'd3, 8'd0);
    wait_done(2000, ok);
    n_cmp++; if (!ok || fire_count - base !== 3) begin n_fail++; $display("FAIL b2b_first: got done=%0b fires=%0d want 1/3", done, fire_count - base); end
    base = fire_count;
    start_scan(5'd0, 5'd1, 16'd1, 8'd1);
    n_cmp++; if (done !== 1'b0 || busy !== 1'b1) begin n_fail++; $display("FAIL b2b_restart: got done=%0b busy=%0b want 0/1", done, busy); end
    wait_done(2000, ok);
    n_cmp++; if (!ok || fire_count - base !== 2 || err_cnt !== 16'd0) begin n_fail++; $display("FAIL b2b_second: got done=%0b fires=%0d err=%0d want 1/2/0", done, fire_count - base, err_cnt); end
    n_cmp++; if (dbl_fire !== 0) begin n_fail++; $display("FAIL fire_consecutive: got %0d want 0", dbl_fire); end
    $display("back-to-back scans: second fires=%0d", fire_count - base);
  endtask

  initial begin
    test_reset();
    test_cfg_error();
    test_full_scan();
    test_mismatch();
    test_timeout();
    test_abort();
    test_reset_mid_settle();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
